// File: rtl/btu_pkg.sv
// Shared types, constants and helpers for the word/block packing blocks.
package btu_pkg;

    localparam int ORDER_MSW_FIRST = 1;
    localparam int ORDER_LSW_FIRST = 0;
    localparam int STAT_W          = 32;

    typedef enum logic {
        S_FILL = 1'b0,
        S_PEND = 1'b1
    } packer_state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_block_fifo.sv
// Show-ahead synchronous FIFO with level output; head data reads as zero when empty.
// Accepts a push while full provided a pop happens in the same cycle.
module sync_block_fifo
    import btu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_valid,
    output logic [clog2(DEPTH+1)-1:0]   o_level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level   = r_wptr - r_rptr;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (w_level == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_valid = ~w_empty;
    assign o_level = w_level;

endmodule

// File: rtl/word_block_packer.sv
// Packs RATIO words of WSIZE into blocks, with flush of zero-padded partial blocks and a block FIFO.
// Optional counters enabled by WORD_BLOCK_PACKER_STATS_EN.
module word_block_packer
    import btu_pkg::*;
#(
    parameter  int WSIZE     = 32,
    parameter  int RATIO     = 4,
    parameter  int DEPTH     = 4,
    parameter  int MSW_FIRST = ORDER_MSW_FIRST,
    localparam int BW        = WSIZE * RATIO,
    localparam int FW        = clog2(RATIO),
    localparam int CW        = clog2(RATIO + 1),
    localparam int LW        = clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WSIZE-1:0]  word_in,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              flush,
    output logic [BW-1:0]     block_out,
    output logic [CW-1:0]     block_words,
    output logic              block_valid,
    input  logic              block_ready,
    output logic [LW-1:0]     level
`ifdef WORD_BLOCK_PACKER_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_blocks,
    output logic [STAT_W-1:0] stat_partial,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    packer_state_t r_state, w_state_nxt;
    logic [FW-1:0] r_fill, w_fill_nxt;
    logic [BW-1:0] r_asm, w_asm_nxt, w_asm_ins;
    logic [CW-1:0] w_eff_fill;
    logic          w_acc;
    logic          w_pop;
    logic          w_room;
    logic          w_push;
    logic [BW-1:0] w_push_data;
    logic [CW-1:0] w_push_words;

    // Ready depends only on local state and level, never on block_ready.
    assign word_ready = (r_state == S_FILL) &
                        ((r_fill != FW'(RATIO - 1)) | (level != LW'(DEPTH)));
    assign w_acc      = word_valid & word_ready;
    assign w_pop      = block_valid & block_ready;
    assign w_room     = (level != LW'(DEPTH)) | w_pop;
    assign w_eff_fill = CW'(r_fill) + CW'(w_acc);

    always_comb begin
        w_asm_ins = r_asm;
        if (w_acc) begin
            for (int k = 0; k < RATIO; k++) begin
                if (r_fill == FW'(k)) begin
                    if (MSW_FIRST != 0) w_asm_ins[(RATIO-1-k)*WSIZE +: WSIZE] = word_in;
                    else                w_asm_ins[k*WSIZE +: WSIZE]           = word_in;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fill_nxt   = r_fill;
        w_asm_nxt    = r_asm;
        w_push       = 1'b0;
        w_push_data  = w_asm_ins;
        w_push_words = w_eff_fill;
        case (r_state)
            S_FILL: begin
                if (w_eff_fill == CW'(RATIO)) begin
                    // Full commit; word_ready already guaranteed FIFO space.
                    w_push     = 1'b1;
                    w_fill_nxt = '0;
                    w_asm_nxt  = '0;
                end else if (flush && (w_eff_fill != '0)) begin
                    if (w_room) begin
                        w_push     = 1'b1;
                        w_fill_nxt = '0;
                        w_asm_nxt  = '0;
                    end else begin
                        w_state_nxt = S_PEND;
                        w_fill_nxt  = w_eff_fill[FW-1:0];
                        w_asm_nxt   = w_asm_ins;
                    end
                end else begin
                    w_fill_nxt = w_eff_fill[FW-1:0];
                    w_asm_nxt  = w_asm_ins;
                end
            end
            S_PEND: begin
                // Held partial block waits for space; new flushes are ignored.
                w_push_data  = r_asm;
                w_push_words = CW'(r_fill);
                if (w_room) begin
                    w_push      = 1'b1;
                    w_fill_nxt  = '0;
                    w_asm_nxt   = '0;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
            r_fill  <= '0;
            r_asm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_asm   <= w_asm_nxt;
        end
    end

    sync_block_fifo #(
        .WIDTH (BW + CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({w_push_words, w_push_data}),
        .i_pop   (w_pop),
        .o_data  ({block_words, block_out}),
        .o_valid (block_valid),
        .o_level (level)
    );

`ifdef WORD_BLOCK_PACKER_STATS_EN
    logic [STAT_W-1:0] r_stat_blocks;
    logic [STAT_W-1:0] r_stat_partial;
    logic [STAT_W-1:0] r_stat_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stat_blocks  <= '0;
            r_stat_partial <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_push && !(&r_stat_blocks)) r_stat_blocks <= r_stat_blocks + 1'b1;
            if (w_push && (w_push_words != CW'(RATIO)) && !(&r_stat_partial))
                r_stat_partial <= r_stat_partial + 1'b1;
            if (word_valid && !word_ready && !(&r_stat_stall)) r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_blocks  = r_stat_blocks;
    assign stat_partial = r_stat_partial;
    assign stat_stall   = r_stat_stall;
`endif

endmodule

// File: tb/tb_word_block_packer.sv
// Bench for word_block_packer: MSW-first and LSW-first instances share stimulus and a reference model.
module tb_word_block_packer;

    logic         clock;
    logic         reset;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         flush;
    logic         block_ready;

    logic         word_ready_m, word_ready_l;
    logic [127:0] block_out_m, block_out_l;
    logic [2:0]   block_words_m, block_words_l;
    logic         block_valid_m, block_valid_l;
    logic [2:0]   level_m, level_l;
`ifdef WORD_BLOCK_PACKER_STATS_EN
    logic [31:0]  sb_m, sp_m, ss_m, sb_l, sp_l, ss_l;
`endif

    word_block_packer #(.WSIZE(32), .RATIO(4), .DEPTH(4), .MSW_FIRST(1)) u_dut_m (
        .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready_m), .flush(flush), .block_out(block_out_m),
        .block_words(block_words_m), .block_valid(block_valid_m),
        .block_ready(block_ready), .level(level_m)
`ifdef WORD_BLOCK_PACKER_STATS_EN
        , .stat_blocks(sb_m), .stat_partial(sp_m), .stat_stall(ss_m)
`endif
    );

    word_block_packer #(.WSIZE(32), .RATIO(4), .DEPTH(4), .MSW_FIRST(0)) u_dut_l (
        .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready_l), .flush(flush), .block_out(block_out_l),
        .block_words(block_words_l), .block_valid(block_valid_l),
        .block_ready(block_ready), .level(level_l)
`ifdef WORD_BLOCK_PACKER_STATS_EN
        , .stat_blocks(sb_l), .stat_partial(sp_l), .stat_stall(ss_l)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   words;
        logic [127:0] dm;
        logic [127:0] dl;
    } blk_t;

    blk_t        sb[$];
    logic [31:0] cur[$];
    bit          m_pend;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic blk_t mk_block();
        blk_t b;
        b.words = 3'(cur.size());
        b.dm = '0;
        b.dl = '0;
        foreach (cur[i]) begin
            b.dm[(3-i)*32 +: 32] = cur[i];
            b.dl[i*32 +: 32]     = cur[i];
        end
        return b;
    endfunction

    function automatic bit model_ready();
        return !m_pend && (cur.size() != 3 || sb.size() != 4);
    endfunction

    task automatic check_outputs();
        logic [2:0] lvl;
        lvl = 3'(sb.size());
        chk("word_ready_m", word_ready_m, model_ready());
        chk("word_ready_l", word_ready_l, model_ready());
        chk("level_m", level_m, lvl);
        chk("level_l", level_l, lvl);
        chk("block_valid_m", block_valid_m, sb.size() > 0);
        chk("block_valid_l", block_valid_l, sb.size() > 0);
        if (sb.size() > 0) begin
            chk("block_out_m", block_out_m, sb[0].dm);
            chk("block_out_l", block_out_l, sb[0].dl);
            chk("block_words_m", block_words_m, sb[0].words);
            chk("block_words_l", block_words_l, sb[0].words);
        end else begin
            chk("empty_out_m", block_out_m, 0);
            chk("empty_words_m", block_words_m, 0);
            chk("empty_out_l", block_out_l, 0);
        end
    endtask

    // Drive one cycle at the negedge, check outputs, then advance the model at the posedge.
    task automatic cycle(input bit wv, input logic [31:0] w, input bit fl, input bit br, output bit acc);
        bit pop, room;
        @(negedge clock);
        word_valid  = wv;
        word_in     = w;
        flush       = fl;
        block_ready = br;
        check_outputs();
        acc  = wv && model_ready();
        pop  = br && sb.size() > 0;
        room = sb.size() < 4 || pop;
        @(posedge clock);
        if (pop) void'(sb.pop_front());
        if (!m_pend) begin
            if (acc) cur.push_back(w);
            if (cur.size() == 4) begin
                sb.push_back(mk_block());
                cur.delete();
            end else if (fl && cur.size() > 0) begin
                if (room) begin
                    sb.push_back(mk_block());
                    cur.delete();
                end else begin
                    m_pend = 1'b1;
                end
            end
        end else if (room) begin
            sb.push_back(mk_block());
            cur.delete();
            m_pend = 1'b0;
        end
    endtask

    task automatic cyc(input bit wv, input logic [31:0] w, input bit fl, input bit br);
        bit a;
        cycle(wv, w, fl, br, a);
    endtask

    initial begin
        bit acc, hold, fl, br;
        int accepted, ncyc;
        logic [31:0] w;
        n_tests = 0;
        n_fail  = 0;
        m_pend  = 1'b0;
        reset = 1'b1; word_in = '0; word_valid = 1'b0; flush = 1'b0; block_ready = 1'b0;
        #3;
        chk("rst_word_ready", word_ready_m, 1'b1);
        chk("rst_block_valid", block_valid_m, 1'b0);
        chk("rst_level", level_m, 0);
        chk("rst_block_out", block_out_m, 0);
        @(negedge clock);
        reset = 1'b0;

        // Full block in both word orders.
        cyc(1, 32'h11, 0, 0);
        cyc(1, 32'h22, 0, 0);
        cyc(1, 32'h33, 0, 0);
        cyc(1, 32'h44, 0, 0);
        #1;
        chk("first_valid", block_valid_m, 1'b1);
        chk("first_msw", block_out_m, 128'h00000011_00000022_00000033_00000044);
        chk("first_lsw", block_out_l, 128'h00000044_00000033_00000022_00000011);
        chk("first_words", block_words_m, 3'd4);
        chk("first_level", level_m, 3'd1);
        cyc(0, 0, 0, 1);

        // Partial flush, then a flush with nothing buffered.
        cyc(1, 32'hA, 0, 0);
        cyc(1, 32'hB, 0, 0);
        cyc(0, 0, 1, 0);
        #1;
        chk("partial_msw", block_out_m, 128'h0000000A_0000000B_00000000_00000000);
        chk("partial_words", block_words_m, 3'd2);
        cyc(0, 0, 1, 0);
        #1;
        chk("empty_flush_level", level_m, 3'd1);
        cyc(0, 0, 0, 1);

        // Fill the FIFO, stall the 4th word, flush into PEND, release with one pop.
        for (int i = 0; i < 16; i++) cyc(1, 32'h100 + 32'(i), 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i), 0, 0);
        #1;
        chk("full_level", level_m, 3'd4);
        chk("full_no_ready", word_ready_m, 1'b0);
        cyc(0, 0, 1, 0);
        #1;
        chk("pend_no_ready", word_ready_m, 1'b0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        #1;
        chk("pend_exit_level", level_m, 3'd4);
        chk("pend_exit_ready", word_ready_m, 1'b1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

        // Reset with fill=3, level=2, then a clean block.
        for (int i = 0; i < 11; i++) cyc(1, 32'h300 + 32'(i), 0, 0);
        @(negedge clock);
        word_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", block_valid_m, 1'b0);
        chk("mid_rst_level", level_m, 0);
        chk("mid_rst_ready", word_ready_m, 1'b1);
        sb.delete();
        cur.delete();
        m_pend = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cyc(1, 32'h51, 0, 0);
        cyc(1, 32'h52, 0, 0);
        cyc(1, 32'h53, 0, 0);
        cyc(1, 32'h54, 0, 0);
        #1;
        chk("post_rst_block", block_out_m, 128'h00000051_00000052_00000053_00000054);
        chk("post_rst_level", level_m, 3'd1);
        cyc(0, 0, 0, 1);

        // Random traffic with held words and sporadic flushes.
        accepted = 0;
        ncyc = 0;
        hold = 1'b0;
        w = '0;
        while (accepted < 1000 && ncyc < 20000) begin
            if (!hold) begin
                hold = 1'($urandom_range(0, 1));
                w = $urandom;
            end
            fl = ($urandom_range(0, 9) == 0);
            br = 1'($urandom_range(0, 1));
            cycle(hold, w, fl, br, acc);
            if (acc) begin
                accepted++;
                hold = 1'b0;
            end
            ncyc++;
        end
        chk("rand_words_accepted", accepted, 1000);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
        #1;
        chk("drain_level", level_m, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/word_block_packer.md
Name: word_block_packer

Overview:
- Parametrised word-to-block packer with an output block FIFO and valid/ready handshakes on both sides.
- Packs RATIO words of WSIZE into one block of WSIZE*RATIO.
- Supports flushing a partial block (zero-padded) and selectable word order.
- Sits between word-oriented producers (bus/UART/DMA) and block engines such as the cipher core; replaces the fixed 32x4 assembler.

Parameters:
- WSIZE, 32, input word width in bits (≥1).
- RATIO, 4, words per block (≥2, power of two).
- DEPTH, 4, block FIFO entries (≥2, power of two).
- MSW_FIRST, 1, 1 = first word received occupies the most-significant slot; 0 = least-significant slot.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, reset, asynchronous, active-high.
- word_in, input, WSIZE, word data.
- word_valid, input, 1, word_in is valid this cycle.
- word_ready, output, 1, packer accepts a word this cycle.
- flush, input, 1, single-cycle request to commit a partial block.
- block_out, output, WSIZE*RATIO, head-of-FIFO block.
- block_words, output, clog2(RATIO+1), count of valid words in the head block (RATIO for a full block).
- block_valid, output, 1, FIFO not empty.
- block_ready, input, 1, consumer takes the head block.
- level, output, clog2(DEPTH+1), blocks currently stored.

Behaviour:
- Handshakes:
  - A word transfers when word_valid & word_ready.
  - A block transfers when block_valid & block_ready.
  - word_ready has no combinational path from block_ready: word_ready = (state==FILL) & ((fill != RATIO-1) | (level != DEPTH)).
- Assembly register asm holds RATIO slots; fill counter 0..RATIO-1.
- Slot placement:
  - Accepted word k goes to slot k.
  - MSW_FIRST=1: slot k = bits [(RATIO-k)*WSIZE-1 -: WSIZE].
  - MSW_FIRST=0: slot k = bits [(k+1)*WSIZE-1 -: WSIZE].
- Commit on the RATIO-th word: {asm, new word} is pushed with block_words=RATIO; fill returns to 0 and asm slots clear to 0 in the same cycle.
- Flush:
  - Same cycle as an accepted word: the word is included first, then the partial block is committed.
  - Effective fill 0: flush is ignored.
  - Effective fill == RATIO: the normal commit happens and the flush is ignored.
  - Partial commits zero-pad unused slots; block_words = number of filled slots.
- State machine:
  - FILL (reset state).
  - PEND: entered when a flush needs a push while level==DEPTH and no pop occurs this cycle.
  - In PEND, word_ready=0 and the partial block is retained; the push occurs on the first cycle with a pop or level<DEPTH, then the FSM returns to FILL.
  - Flush pulses in PEND are ignored.
- FIFO behaviour:
  - Show-ahead: a block committed at edge N is visible on block_out with block_valid=1 after edge N. Minimum latency is one cycle from the final word to block_valid.
  - Simultaneous push and pop is legal at any level, including full (PEND exit) and empty (block_valid rises next cycle). Level is unchanged.
  - When empty, block_out=0 and block_words=0.
  - Pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; level = wptr-rptr.
- Reset (asynchronous, any time, including mid-block or in PEND):
  - FIFO empties, fill=0, asm=0, FSM→FILL.
  - Outputs: word_ready=1, block_valid=0, block_out=0, block_words=0, level=0.
  - Contents in flight are discarded.
- No data is dropped under any handshake sequence; the producer must hold word_in/word_valid until accepted.

Optional Feature:
- Macro WORD_BLOCK_PACKER_STATS_EN.
- When defined:
  - Adds outputs stat_blocks[31:0] (blocks pushed) and stat_partial[31:0] (partial blocks pushed) plus stat_stall[31:0].
  - stat_stall counts cycles with word_valid & ~word_ready.
  - All counters saturate at 2^32-1 and are cleared by reset.
- When undefined: the ports and logic are absent; function is otherwise identical.

Decomposition:
- Package btu_pkg:
  - clog2 function.
  - Word-order constants ORDER_MSW_FIRST=1, ORDER_LSW_FIRST=0.
  - Stats counter width constant STAT_W=32.
- Sub-module sync_block_fifo (width, depth; show-ahead, level output, zero output when empty) is instantiated for the block store. Packer FSM and assembly logic stay in the top module.

Test Plan:
- WSIZE=32, RATIO=4, MSW_FIRST=1; push words 0x11,0x22,0x33,0x44 with block_ready=0 → one cycle later block_valid=1, block_out=0x00000011_00000022_00000033_00000044, block_words=4, level=1.
- Same stream with MSW_FIRST=0 → block_out=0x00000044_00000033_00000022_00000011.
- Push 0xA,0xB, then flush alone → block_out=0x0000000A_0000000B_00000000_00000000, block_words=2; flush with fill 0 → level unchanged.
- block_ready=0, push 4 full blocks (DEPTH=4) → level=4. Then:
  - Push 3 words: word_ready=0 before the 4th.
  - Push 2 words + flush: FSM in PEND.
  - Pulse block_ready once → partial block pushed the same cycle, level stays 4, word_ready returns to 1.
- Random word_valid/block_ready at 50% duty, 1000 words, random flushes → scoreboard sees every word in order, zero padding correct, level never exceeds DEPTH.
- Assert reset mid-block (fill=3, level=2) → same cycle block_valid=0, level=0, word_ready=1. The next 4 words form a clean block with no stale data.
